// File: rtl/uart_tx_peripheral.sv
// Memory-mapped 8N1 UART transmitter.
// Writes to the data address are queued in a small FIFO. The FSM drains the
// FIFO onto the serial pin. Reads of the status address return FIFO and line
// state on the shared data bus. The bus is released at all other times.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | line high, waiting for a queued byte
// START | start bit (line low) for one bit period
// DATA  | eight data bits, LSB first, one bit period each
// STOP  | stop bit (line high); chains straight into START if queued

module uart_tx_peripheral #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] mem_address,
  inout  wire  [63:0] data_bus,
  input  logic        mem_write_en,
  input  logic        mem_read,
  output logic        tx,
  output logic        tx_busy
);

  localparam logic [31:0] TX_ADDRESS     = 32'd252;
  localparam logic [31:0] STATUS_ADDRESS = 32'd253;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      fifo_q [FIFO_DEPTH];
  logic [7:0]      fifo_d [FIFO_DEPTH];

  logic fifo_empty;
  logic fifo_full;
  logic baud_done;
  logic push_req;
  logic push;
  logic pop;
  logic status_rd;
  logic overflow_set;
  logic busy;
  logic unused_bus_hi;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign baud_done  = (baud_q == BAUD_LAST);
  assign push_req   = mem_write_en && (mem_address == TX_ADDRESS);
  assign status_rd  = mem_read && (mem_address == STATUS_ADDRESS);

  // Only the low byte of a data write is meaningful.
  assign unused_bus_hi = ^data_bus[63:8];

  // Status is driven combinationally only during a status read.
  assign data_bus = status_rd ? {59'b0, overflow_q, busy, fifo_empty, fifo_full}
                              : 64'bz;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      fifo_q     <= '{default: '0};
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      fifo_q     <= fifo_d;
    end
  end

  // Next-state logic; a pop happens whenever the FSM enters START.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          state_d = S_START;
          pop     = 1'b1;
        end
      end
      S_START: begin
        if (baud_done) state_d = S_DATA;
      end
      S_DATA: begin
        if (baud_done && (bit_idx_q == 3'd7)) state_d = S_STOP;
      end
      S_STOP: begin
        if (baud_done) begin
          if (!fifo_empty) begin
            state_d = S_START;
            pop     = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Baud/bit counters, shift register, FIFO pointers and overflow flag.
  always_comb begin
    baud_d    = baud_q + CW'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    fifo_d    = fifo_q;

    // Counter restarts on every state entry and at each bit boundary.
    if ((state_q == S_IDLE) || (state_d != state_q) || baud_done) baud_d = '0;

    if ((state_q == S_START) && baud_done) bit_idx_d = 3'd0;
    if ((state_q == S_DATA) && baud_done)  bit_idx_d = bit_idx_q + 3'd1;

    if (pop)
      shift_d = fifo_q[rd_ptr_q[AW-1:0]];
    else if ((state_q == S_DATA) && baud_done)
      shift_d = {1'b0, shift_q[7:1]};

    // A pop frees a slot in the same cycle, so a full FIFO still accepts.
    push         = push_req && (!fifo_full || pop);
    overflow_set = push_req && fifo_full && !pop;

    if (push) fifo_d[wr_ptr_q[AW-1:0]] = data_bus[7:0];
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};

    if (overflow_set)   overflow_d = 1'b1;
    else if (status_rd) overflow_d = 1'b0;
    else                overflow_d = overflow_q;
  end

  // Line and busy outputs decoded from the current state.
  always_comb begin
    tx   = 1'b1;
    busy = (state_q != S_IDLE);
    case (state_q)
      S_START: tx = 1'b0;
      S_DATA:  tx = shift_q[0];
      default: tx = 1'b1;
    endcase
  end

  assign tx_busy = busy;

endmodule

// File: tb/tb_uart_tx_peripheral.sv
// Bench for uart_tx_peripheral with a frame-level reference model.
// The model tracks a byte queue and the position inside the current frame;
// line level is derived arithmetically from that position.

module tb_uart_tx_peripheral;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;
  localparam logic [31:0] TX_ADDR   = 32'd252;
  localparam logic [31:0] STAT_ADDR = 32'd253;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] mem_address;
  logic        mem_write_en;
  logic        mem_read;
  logic        tx;
  logic        tx_busy;
  tri1  [63:0] data_bus;
  logic        drv_en;
  logic [63:0] drv_val;

  assign data_bus = drv_en ? drv_val : 64'bz;

  always #5 clock = ~clock;

  uart_tx_peripheral #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .mem_address  (mem_address),
    .data_bus     (data_bus),
    .mem_write_en (mem_write_en),
    .mem_read     (mem_read),
    .tx           (tx),
    .tx_busy      (tx_busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference model
  logic [7:0] mq[$];
  logic [7:0] sent[$];
  logic       m_active = 1'b0;
  logic [7:0] m_byte = 8'h00;
  int         m_t = 0;
  logic       m_ovf = 1'b0;

  logic [63:0] last_bus;
  int          busy_cnt;
  logic        cap_en = 1'b0;
  logic        cap[$];

  function automatic logic m_tx();
    if (!m_active)         return 1'b1;
    if (m_t < CPB)         return 1'b0;
    if (m_t < 9 * CPB)     return m_byte[(m_t - CPB) / CPB];
    return 1'b1;
  endfunction

  function automatic logic [63:0] m_status();
    return {59'b0, m_ovf, m_active, (mq.size() == 0), (mq.size() == 4)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input logic r, input logic [31:0] a, input logic w,
                              input logic rd, input logic [7:0] d);
    int  sz;
    logic pop;
    logic set;
    if (!r) begin
      mq.delete();
      m_active = 1'b0;
      m_t      = 0;
      m_ovf    = 1'b0;
      return;
    end
    sz  = mq.size();
    pop = 1'b0;
    if (m_active) begin
      if (m_t == FRAME - 1) begin
        if (sz > 0) pop = 1'b1;
        else        m_active = 1'b0;
      end else begin
        m_t++;
      end
    end else if (sz > 0) begin
      pop = 1'b1;
    end
    if (pop) begin
      m_byte   = mq.pop_front();
      m_active = 1'b1;
      m_t      = 0;
      sent.push_back(m_byte);
    end
    set = 1'b0;
    if (w && (a == TX_ADDR)) begin
      if ((sz < 4) || pop) mq.push_back(d);
      else                 set = 1'b1;
    end
    if (set)                         m_ovf = 1'b1;
    else if (rd && (a == STAT_ADDR)) m_ovf = 1'b0;
  endtask

  // One bus cycle: drive, check the combinational bus, clock, check the line.
  task automatic step(input logic r, input logic [31:0] a, input logic w,
                      input logic rd, input logic [7:0] d);
    reset        = r;
    mem_address  = a;
    mem_write_en = w;
    mem_read     = rd;
    drv_en       = w;
    drv_val      = {56'hA5A55A5AC3C33C, d};
    #1;
    last_bus = data_bus;
    if (!w) begin
      if (rd && (a == STAT_ADDR)) chk("status_bus", data_bus, m_status());
      else                        chk("bus_z", data_bus, '1);
    end
    @(posedge clock);
    model_update(r, a, w, rd, d);
    @(negedge clock);
    chk("tx", {63'b0, tx}, {63'b0, m_tx()});
    chk("tx_busy", {63'b0, tx_busy}, {63'b0, m_active});
    if (tx_busy) busy_cnt++;
    if (cap_en) cap.push_back(tx);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 32'd0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic wr(input logic [7:0] b);
    step(1'b1, TX_ADDR, 1'b1, 1'b0, b);
  endtask

  task automatic rd_status();
    step(1'b1, STAT_ADDR, 1'b0, 1'b1, 8'h00);
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((m_active || (mq.size() != 0)) && (k < budget)) begin
      idle(1);
      k++;
    end
    if (k >= budget) chk("drain_timeout", 64'(k), 64'(budget - 1));
  endtask

  initial begin
    logic lv55 [10];
    logic lvbb [20];
    logic [39:0] got5;
    logic [47:0] got6;
    lv55 = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    lvbb = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 1,
             0, 1, 1, 1, 1, 0, 0, 0, 0, 1};

    // reset
    step(1'b0, 32'd0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 32'd0, 1'b0, 1'b0, 8'h00);
    rd_status();
    chk("reset_status", last_bus, 64'h2);
    chk("reset_tx", {63'b0, tx}, 64'h1);
    chk("reset_busy", {63'b0, tx_busy}, 64'h0);
    step(1'b1, TX_ADDR, 1'b0, 1'b1, 8'h00);

    // single frame 0x55
    busy_cnt = 0;
    wr(8'h55);
    chk("push_edge_tx", {63'b0, tx}, 64'h1);
    cap.delete();
    cap_en = 1'b1;
    idle(FRAME + 4);
    cap_en = 1'b0;
    for (int i = 0; i < FRAME + 4; i++)
      chk("frame55", {63'b0, cap[i]}, (i < FRAME) ? {63'b0, lv55[i / CPB]} : 64'h1);
    chk("busy55", 64'(busy_cnt), 64'd40);
    rd_status();
    chk("status_after55", last_bus, 64'h2);

    // fill and overflow
    sent.delete();
    for (int b = 1; b <= 5; b++) wr(8'(b));
    wr(8'h06);
    rd_status();
    chk("ovf_status", last_bus, 64'hD);
    rd_status();
    chk("ovf_cleared", last_bus, 64'h5);
    step(1'b1, TX_ADDR, 1'b0, 1'b1, 8'h00);
    drain(6 * FRAME);
    idle(2);
    chk("fill_count", 64'(sent.size()), 64'd5);
    got5 = '0;
    for (int i = 0; i < 5 && i < sent.size(); i++) got5 = {got5[31:0], sent[i]};
    chk("fill_order", {24'b0, got5}, 64'h0102030405);

    // back-to-back
    busy_cnt = 0;
    wr(8'hA0);
    cap.delete();
    cap_en = 1'b1;
    wr(8'h0F);
    idle(2 * FRAME + 5);
    cap_en = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++)
      chk("b2b_line", {63'b0, cap[i]}, {63'b0, lvbb[i / CPB]});
    chk("b2b_busy", 64'(busy_cnt), 64'd80);

    // push/pop collision at the end of a stop bit while full
    sent.delete();
    for (int b = 0; b < 5; b++) wr(8'h31 + 8'(b));
    idle(36);
    wr(8'h77);
    rd_status();
    chk("collide_status", last_bus, 64'h5);
    drain(7 * FRAME);
    idle(2);
    chk("collide_count", 64'(sent.size()), 64'd6);
    got6 = '0;
    for (int i = 0; i < 6 && i < sent.size(); i++) got6 = {got6[39:0], sent[i]};
    chk("collide_order", {16'b0, got6}, 64'h313233343577);

    // reset mid-frame during data bit 3 of 0xFF with two bytes queued
    sent.delete();
    wr(8'hFF);
    wr(8'h11);
    wr(8'h22);
    idle(16);
    step(1'b0, 32'd0, 1'b0, 1'b0, 8'h00);
    chk("midrst_tx", {63'b0, tx}, 64'h1);
    chk("midrst_busy", {63'b0, tx_busy}, 64'h0);
    rd_status();
    chk("midrst_status", last_bus, 64'h2);
    busy_cnt = 0;
    idle(3 * FRAME);
    chk("midrst_quiet", 64'(busy_cnt), 64'd0);
    chk("midrst_sent", 64'(sent.size()), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_peripheral.md
# uart_tx_peripheral

Memory-mapped UART transmitter on the processor memory bus, alongside RAM, ROM and the GPIO block. The datapath writes bytes to a data register; they are queued in a 4-entry FIFO. Queued bytes are serialised as 8N1 frames on a single output pin. A status register reports FIFO and line state. The block is decoded at two fixed addresses just below the GPIO pair, so the top-level peripheral select excludes RAM and ROM for these addresses too.

## Interface
- TX_ADDRESS, 32'd252, write-only data register; a write queues data_bus[7:0]
- STATUS_ADDRESS, 32'd253, read-only status register
- CLKS_PER_BIT, 16, clock cycles per serial bit (≥2)
- FIFO_DEPTH, 4, queue entries (power of two)

- clock  input  1  system clock, rising edge
- reset  input  1  synchronous, active-low reset
- mem_address  input  32  bus address from datapath
- data_bus  inout  64  shared memory data bus
- mem_write_en  input  1  bus write strobe
- mem_read  input  1  bus read strobe
- tx  output  1  serial line, idle high
- tx_busy  output  1  high while a frame is on the line

## Operation
- Push: takes effect at a rising edge when mem_address==TX_ADDRESS, mem_write_en=1, and the FIFO is not full or a pop occurs in the same cycle. data_bus[7:0] is stored; bits 63:8 are ignored.
- Write while full with no pop: the byte is dropped and the sticky overflow flag is set.
- Status read: when mem_address==STATUS_ADDRESS and mem_read=1, data_bus is driven combinationally with {59'b0, overflow, busy, empty, full} (bit0 = full).
- data_bus is high-Z at all other times, including reads of TX_ADDRESS.
- The overflow flag clears at the edge ending a status read. If overflow is set and cleared in the same cycle, the set wins.
- FSM states are IDLE, START, DATA, STOP.
  - IDLE: tx=1. If the FIFO is non-empty, pop the head into the shift register and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with the bit index at 0.
  - DATA: tx=shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles; shift right after each bit. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then, if the FIFO is non-empty, pop and go directly to START; otherwise go to IDLE.
- Counters:
  - Baud counter runs 0..CLKS_PER_BIT-1 and resets on every state entry.
  - Bit index is 3 bits.
  - FIFO read and write pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
  - full = pointers equal except MSB; empty = pointers equal.
- busy = tx_busy = (state != IDLE).
- Reset (reset==0 at an edge):
  - State returns to IDLE, tx=1, FIFO emptied, overflow=0, counters=0.
  - Reset mid-frame aborts the frame immediately, with no stop bit completion.

## Timing
- Reset values: tx=1, tx_busy=0, status reads 64'h2 (empty).
- A push at edge N makes empty=0 from N. From IDLE, the pop occurs at edge N+1, so tx=0 and tx_busy=1 from N+1.
- One frame is exactly 10×CLKS_PER_BIT cycles from START entry to STOP exit.
- Back-to-back queued bytes have no idle cycle between the stop bit and the next start bit.
- Simultaneous push and pop with the FIFO full: both occur; count unchanged; no overflow.
- Simultaneous push and pop with the FIFO empty cannot happen, because a pop requires non-empty.

## Test plan
- **Reset:** hold reset=0 for 2 cycles, then read STATUS → data_bus=64'h2, tx=1, tx_busy=0. At all other times data_bus=Z.
- **Single frame** (CLKS_PER_BIT=4): write 0x55 → starting 1 cycle later, tx shows 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop), each level lasting 4 cycles. tx_busy is high for 40 cycles, then status returns to 64'h2.
- **Fill and overflow:** 5 consecutive writes 0x01..0x05 while idle.
  - The first byte is popped immediately, so 4 remain and the 5th is accepted.
  - A 6th write of 0x06 → status=64'hD (overflow, busy, full).
  - A second status read → 64'h5.
  - Line output is 0x01..0x05 in order; 0x06 is never sent.
- **Back-to-back:** queue 0xA0 and 0x0F → tx goes from the first stop bit directly to the second start bit, with no extra high cycle. Total busy time is 80 cycles.
- **Reset mid-frame:** assert reset during DATA bit 3 of 0xFF with 2 bytes queued → tx=1 and tx_busy=0 after that edge, status=64'h2, and no further frames are sent.
- **Push/pop collision:** with the FIFO full, write on the exact cycle STOP ends → the new byte is accepted, overflow stays 0, and full remains 1.
